dsss_spreader: RTL and testbench
================================

Name: dsss_spreader

Overview:
- Upstream neighbour of the BPSK/ASK modulator selector. Accepts parallel data words over a valid/ready handshake and serializes them MSB first.
- Spreads each data bit with a PN chip sequence from an LFSR: chip = data_bit XOR pn.
- Drives the modulator's 1-bit data input at the chip rate, derived from clk by an integer divider.

Parameters:
- DATA_WIDTH, 8: bits per input word.
- LFSR_WIDTH, 5: PN generator length. The m-sequence period is 2^LFSR_WIDTH-1.
- LFSR_TAPS, 5'b10100: feedback mask. Default polynomial is x^5+x^3+1.
- LFSR_SEED, 5'b00001: value loaded at the start of every data bit. Must be nonzero.
- CHIPS_PER_BIT, 31: chips per data bit. Legal range 1..1023.
- CHIP_DIV, 16: clk cycles per chip. Legal range 1..65535.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- in_data, in, DATA_WIDTH: word to transmit.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: block accepts the word this cycle.
- chip_out, out, 1: spread chip; connects to the modulator data_in.
- chip_valid, out, 1: high while a word is being transmitted.
- chip_tick, out, 1: one-cycle pulse on the first clk of every chip.
- bit_start, out, 1: one-cycle pulse on the first clk of every data bit.
- busy, out, 1: high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE and all counters=0. Outputs: chip_out=0, chip_valid=0, chip_tick=0, bit_start=0, busy=0, in_ready=0 while rst is low.
- Word acceptance: a word is accepted on the rising edge where in_valid&&in_ready=1. in_data is captured into the shift register.
- Settings at acceptance: bit_idx=0, chip_idx=0, div_cnt=0, lfsr=LFSR_SEED, state=SEND.
- States:
  - IDLE: in_ready=1. chip_out=0, chip_valid=0. On acceptance, go to SEND (or PREAMBLE when the optional feature is compiled in).
  - SEND: in_ready=0, except on the final clk of the word.
    - div_cnt counts 0..CHIP_DIV-1 and wraps to 0.
    - At wrap, chip_idx increments and the LFSR steps.
    - When chip_idx wraps at CHIPS_PER_BIT-1: bit_idx increments, the shift register shifts left, and lfsr reloads LFSR_SEED.
- LFSR step: fb = ^(lfsr & LFSR_TAPS); lfsr <= {lfsr[LFSR_WIDTH-2:0], fb}; pn = lfsr[LFSR_WIDTH-1].
- LFSR lock-up guard: if lfsr==0, the next value is 1.
- Outputs in SEND:
  - chip_out = shreg[DATA_WIDTH-1] ^ pn.
  - chip_valid=1, busy=1.
  - chip_tick=1 when div_cnt==0.
  - bit_start=1 when div_cnt==0 && chip_idx==0.
- Latency: the first chip is presented on the clk immediately after the accepting edge.
- Each word occupies exactly DATA_WIDTH*CHIPS_PER_BIT*CHIP_DIV clks.
- Final clk of a word (div_cnt==CHIP_DIV-1, chip_idx==CHIPS_PER_BIT-1, bit_idx==DATA_WIDTH-1):
  - in_ready=1.
  - If a word is accepted, the next word starts next clk with no gap (state stays SEND, counters and LFSR reinitialised).
  - Otherwise state goes to IDLE.
- in_valid while busy (other than the final clk) is ignored. in_data must be held by the source until accepted.
- CHIP_DIV=1: chip_tick is high every clk in SEND.
- CHIPS_PER_BIT=1: bit_start equals chip_tick.
- Reset mid-word: the word is discarded and outputs drop to reset values immediately.
- When the block re-enters IDLE, chip_out returns to 0 on that clk.

Optional Feature:
- Macro: DSSS_PREAMBLE_EN.
- Defined:
  - Acceptance from IDLE enters PREAMBLE first.
  - PREAMBLE sends 4 data bits of value 0 (pure PN, same chip and bit timing, bit_start pulses) for receiver code acquisition, then enters SEND with the captured word.
  - chip_valid=1 and busy=1 during PREAMBLE.
  - Back-to-back words accepted on a final clk skip the preamble.
- Undefined: no PREAMBLE state; acceptance goes straight to SEND.

Test Plan:
- Reset: rst=0 mid-word -> chip_out=0, chip_valid=0, busy=0 same cycle. After release: in_ready=1 the first clk, IDLE.
- PN sequence (CHIP_DIV=1, defaults): accept 0x00 -> first 8 chips 0,0,0,0,1,0,0,1. Each 31-chip bit contains exactly 16 ones. bit_start every 31 clks.
- Spreading: accept 0x80 -> bit 0 chips 1,1,1,1,0,1,1,0 (inverted PN). Bits 1..7 chips match the 0x00 case.
- Timing (CHIP_DIV=16): accept 0xA5 -> chip_tick every 16 clks. busy high exactly 8*31*16=3968 clks. Then in_ready=1 and IDLE.
- Back-to-back: in_valid held with 0x3C then 0xC3 -> second word accepted on the final clk of the first. bit_start contiguous, no idle gap. chip_valid never drops.
- Preamble (DSSS_PREAMBLE_EN): accept 0xFF from IDLE -> 4*31 pure-PN chips, then inverted PN. A back-to-back second word gets no preamble.

Source files
------------

// File: rtl/dsss_spreader.sv
// DSSS spreader: serializes parallel words MSB first and XORs each bit with an LFSR PN chip stream.
// Optional PN-only preamble before a word started from idle: define DSSS_PREAMBLE_EN.
module dsss_spreader #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    LFSR_WIDTH    = 5,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS     = 5'b10100,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED     = 5'b00001,
    parameter int                    CHIPS_PER_BIT = 31,
    parameter int                    CHIP_DIV      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  chip_out,
    output logic                  chip_valid,
    output logic                  chip_tick,
    output logic                  bit_start,
    output logic                  busy
);

    localparam int DIV_W  = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int CHIP_W = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
`ifdef DSSS_PREAMBLE_EN
    localparam int NBITS_MAX = (DATA_WIDTH > 4) ? DATA_WIDTH : 4;
`else
    localparam int NBITS_MAX = DATA_WIDTH;
`endif
    localparam int BIT_W = (NBITS_MAX > 1) ? $clog2(NBITS_MAX) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CHIP_DIV - 1);
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(CHIPS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
`ifdef DSSS_PREAMBLE_EN
    localparam logic [BIT_W-1:0]  PRE_LAST  = BIT_W'(3);

    typedef enum logic [1:0] {IDLE, SEND, PREAMBLE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [CHIP_W-1:0]       chip_q, chip_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;

    logic active, div_last, chip_last, bit_last, word_last, accept, data_bit;

    // Galois-free Fibonacci step; an all-zero register is forced back onto the sequence.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        logic fb;
        fb = ^(s & LFSR_TAPS);
        if (s == '0) begin
            return LFSR_WIDTH'(1);
        end
        return {s[LFSR_WIDTH-2:0], fb};
    endfunction

    assign active    = (state_q != IDLE);
    assign div_last  = (div_q == DIV_LAST);
    assign chip_last = (chip_q == CHIP_LAST);
    assign bit_last  = (bit_q == BIT_LAST);
    assign word_last = (state_q == SEND) && div_last && chip_last && bit_last;
    assign in_ready  = rst && ((state_q == IDLE) || word_last);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        chip_d  = chip_q;
        bit_d   = bit_q;
        lfsr_d  = lfsr_q;
        shreg_d = shreg_q;

        if (active) begin
            if (div_last) begin
                div_d = '0;
                if (chip_last) begin
                    chip_d = '0;
                    bit_d  = bit_q + BIT_W'(1);
                    lfsr_d = LFSR_SEED;
                    if (state_q == SEND) begin
                        shreg_d = shreg_q << 1;
                    end
                end else begin
                    chip_d = chip_q + CHIP_W'(1);
                    lfsr_d = lfsr_step(lfsr_q);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
`ifdef DSSS_PREAMBLE_EN
            if ((state_q == PREAMBLE) && div_last && chip_last && (bit_q == PRE_LAST)) begin
                state_d = SEND;
                bit_d   = '0;
            end
`endif
            if (word_last) begin
                state_d = IDLE;
                div_d   = '0;
                chip_d  = '0;
                bit_d   = '0;
                lfsr_d  = LFSR_SEED;
            end
        end

        // Acceptance (from idle or on the final clk of a word) restarts every counter.
        if (accept) begin
            shreg_d = in_data;
            div_d   = '0;
            chip_d  = '0;
            bit_d   = '0;
            lfsr_d  = LFSR_SEED;
`ifdef DSSS_PREAMBLE_EN
            state_d = (state_q == IDLE) ? PREAMBLE : SEND;
`else
            state_d = SEND;
`endif
        end
    end

    always_comb begin
        data_bit   = 1'b0;
        chip_out   = 1'b0;
        chip_valid = 1'b0;
        chip_tick  = 1'b0;
        bit_start  = 1'b0;
        busy       = 1'b0;
        if (active) begin
            // Preamble chips carry a zero data bit, i.e. pure PN.
            data_bit   = (state_q == SEND) ? shreg_q[DATA_WIDTH-1] : 1'b0;
            chip_out   = data_bit ^ lfsr_q[LFSR_WIDTH-1];
            chip_valid = 1'b1;
            busy       = 1'b1;
            chip_tick  = (div_q == '0);
            bit_start  = (div_q == '0) && (chip_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            chip_q  <= '0;
            bit_q   <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            chip_q  <= chip_d;
            bit_q   <= bit_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: tb/tb_dsss_spreader.sv
// Directed bench for dsss_spreader: three instances (CHIP_DIV=1, CHIP_DIV=16, CHIPS_PER_BIT=1).
// Expectations adapt to DSSS_PREAMBLE_EN (4 leading pure-PN bits on words started from idle).
module tb_dsss_spreader;

`ifdef DSSS_PREAMBLE_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] a_in_data, b_in_data, c_in_data;
    logic       a_in_valid, b_in_valid, c_in_valid;
    logic       a_in_ready, a_chip_out, a_chip_valid, a_chip_tick, a_bit_start, a_busy;
    logic       b_in_ready, b_chip_out, b_chip_valid, b_chip_tick, b_bit_start, b_busy;
    logic       c_in_ready, c_chip_out, c_chip_valid, c_chip_tick, c_bit_start, c_busy;

    // Hand-derived 31-chip m-sequence from seed 00001, taps 10100; chip i is pn_seq[30-i].
    logic [30:0] pn_seq;
    int n_chk;
    int n_fail;

    dsss_spreader #(.CHIP_DIV(1)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .chip_out(a_chip_out), .chip_valid(a_chip_valid), .chip_tick(a_chip_tick),
        .bit_start(a_bit_start), .busy(a_busy)
    );

    dsss_spreader #(.CHIP_DIV(16)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .chip_out(b_chip_out), .chip_valid(b_chip_valid), .chip_tick(b_chip_tick),
        .bit_start(b_bit_start), .busy(b_busy)
    );

    dsss_spreader #(.CHIPS_PER_BIT(1), .CHIP_DIV(3)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .chip_out(c_chip_out), .chip_valid(c_chip_valid), .chip_tick(c_chip_tick),
        .bit_start(c_bit_start), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called with the first chip of word w on a_chip_out; returns one clk after its final chip.
    task automatic send_a(input logic [7:0] w, input int pre, input logic chain, input logic [7:0] nxt);
        logic d;
        logic e;
        int   ones;
        a_in_data  = nxt;
        a_in_valid = chain;
        for (int b = 0; b < pre + 8; b++) begin
            ones = 0;
            d    = (b < pre) ? 1'b0 : w[7-(b-pre)];
            for (int c = 0; c < 31; c++) begin
                e = d ^ pn_seq[30-c];
                check("a_chip", 32'(a_chip_out), 32'(e));
                check("a_bit_start", 32'(a_bit_start), 32'(c == 0));
                check("a_tick", 32'(a_chip_tick), 32'(1));
                check("a_valid", 32'(a_chip_valid), 32'(1));
                check("a_ready", 32'(a_in_ready), 32'((b == pre + 7) && (c == 30)));
                ones += int'(a_chip_out);
                @(posedge clk); #1;
            end
            check("a_ones", 32'(ones), d ? 32'(15) : 32'(16));
        end
    endtask

    task automatic check_a_idle();
        check("a_idle_busy", 32'(a_busy), 32'(0));
        check("a_idle_chip", 32'(a_chip_out), 32'(0));
        check("a_idle_valid", 32'(a_chip_valid), 32'(0));
        check("a_idle_ready", 32'(a_in_ready), 32'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         cyc;
        int         bitn;
        int         chipn;
        logic       d;
        logic [7:0] w;

        pn_seq     = 31'b0000_1001_0110_0111_1100_0110_1110_101;
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b0;
        a_in_data  = '0; a_in_valid = 1'b0;
        b_in_data  = '0; b_in_valid = 1'b0;
        c_in_data  = '0; c_in_valid = 1'b0;

        // Reset held low
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(a_in_ready), 32'(0));
        check("rst_busy", 32'(a_busy), 32'(0));
        check("rst_valid", 32'(a_chip_valid), 32'(0));
        check("rst_chip", 32'(a_chip_out), 32'(0));
        #2 rst = 1'b1;
        #1;
        check("rel_ready_a", 32'(a_in_ready), 32'(1));
        check("rel_ready_b", 32'(b_in_ready), 32'(1));
        check("rel_busy", 32'(a_busy), 32'(0));
        @(posedge clk); #1;

        // Word 0x00: pure PN chips
        a_in_valid = 1'b1; a_in_data = 8'h00;
        check("acc00_ready", 32'(a_in_ready), 32'(1));
        @(posedge clk); #1;
        send_a(8'h00, PRE, 1'b0, 8'h00);
        check_a_idle();

        // Word 0x80: first data bit inverts PN
        a_in_valid = 1'b1; a_in_data = 8'h80;
        @(posedge clk); #1;
        send_a(8'h80, PRE, 1'b0, 8'h00);
        check_a_idle();

        // Back-to-back 0x3C then 0xC3, second accepted on the final clk of the first
        a_in_valid = 1'b1; a_in_data = 8'h3C;
        @(posedge clk); #1;
        send_a(8'h3C, PRE, 1'b1, 8'hC3);
        send_a(8'hC3, 0, 1'b0, 8'h00);
        check_a_idle();

        // CHIP_DIV=16 timing with 0xA5
        w = 8'hA5;
        b_in_valid = 1'b1; b_in_data = w;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        cyc = 0;
        while (b_busy && cyc < 20000) begin
            bitn  = cyc / 496;
            chipn = (cyc / 16) % 31;
            check("b_tick", 32'(b_chip_tick), 32'(cyc % 16 == 0));
            check("b_bit_start", 32'(b_bit_start), 32'(cyc % 496 == 0));
            if ((cyc % 16 == 0) && (bitn < PRE + 8)) begin
                d = (bitn < PRE) ? 1'b0 : w[7-(bitn-PRE)];
                check("b_chip", 32'(b_chip_out), 32'(d ^ pn_seq[30-chipn]));
            end
            cyc++;
            @(posedge clk); #1;
        end
        check("b_busy_len", 32'(cyc), 32'((8 + PRE) * 31 * 16));
        check("b_end_ready", 32'(b_in_ready), 32'(1));
        check("b_end_valid", 32'(b_chip_valid), 32'(0));
        check("b_end_chip", 32'(b_chip_out), 32'(0));

        // CHIPS_PER_BIT=1: bit_start equals chip_tick, PN stays at the seed
        c_in_valid = 1'b1; c_in_data = w;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        cyc = 0;
        while (c_busy && cyc < 1000) begin
            bitn = cyc / 3;
            check("c_tick", 32'(c_chip_tick), 32'(cyc % 3 == 0));
            check("c_bit_start", 32'(c_bit_start), 32'(cyc % 3 == 0));
            if (bitn < PRE + 8) begin
                d = (bitn < PRE) ? 1'b0 : w[7-(bitn-PRE)];
                check("c_chip", 32'(c_chip_out), 32'(d));
            end
            cyc++;
            @(posedge clk); #1;
        end
        check("c_busy_len", 32'(cyc), 32'((8 + PRE) * 3));

        // Reset mid-word on A
        a_in_valid = 1'b1; a_in_data = 8'hFF;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        check("mid_busy", 32'(a_busy), 32'(1));
        check("mid_chip", 32'(a_chip_out), (PRE > 0) ? 32'(0) : 32'(1));
        check("mid_bit_start", 32'(a_bit_start), 32'(1));
        rst = 1'b0;
        #1;
        check("mrst_chip", 32'(a_chip_out), 32'(0));
        check("mrst_valid", 32'(a_chip_valid), 32'(0));
        check("mrst_busy", 32'(a_busy), 32'(0));
        check("mrst_tick", 32'(a_chip_tick), 32'(0));
        check("mrst_bit_start", 32'(a_bit_start), 32'(0));
        check("mrst_ready", 32'(a_in_ready), 32'(0));
        #1 rst = 1'b1;
        #1;
        check("mrel_ready", 32'(a_in_ready), 32'(1));
        check("mrel_busy", 32'(a_busy), 32'(0));
        @(posedge clk); #1;
        check_a_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
